// File: rtl/axi_dw_rd_sched_pkg.sv
// Shared types and helpers for the AXI data-width converter read scheduler.
// Holds the default AR channel struct, slot record, burst codes and lane-offset advance.
package axi_dw_rd_sched_pkg;

    localparam int unsigned AxiIdWidthDef   = 4;
    localparam int unsigned AxiAddrWidthDef = 32;
    localparam int unsigned MaxIdWidth      = 16;
    localparam int unsigned MaxOffWidth     = 8;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef struct packed {
        logic [AxiIdWidthDef-1:0]   id;
        logic [AxiAddrWidthDef-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
    } axi_ar_t;

    typedef struct packed {
        logic                   valid;
        logic [MaxIdWidth-1:0]  id;
        logic [MaxOffWidth-1:0] offset;
        logic [2:0]             size;
        logic [1:0]             burst;
        logic [7:0]             beats_left;
    } slot_t;

    // Align to the next beat boundary of the burst size, wrapping at the port width.
    function automatic logic [MaxOffWidth-1:0] next_offset(
        input logic [MaxOffWidth-1:0] off,
        input logic [2:0]             size,
        input logic [MaxOffWidth-1:0] mask
    );
        logic [15:0] t;
        t = 16'(off) >> size;
        t = (t + 16'd1) << size;
        return t[MaxOffWidth-1:0] & mask;
    endfunction

endpackage

// File: rtl/axi_dw_rd_sched_alloc.sv
// Slot allocator: lowest free slot select plus ID-conflict CAM over live slots.
// Works purely on registered slot state supplied by the scheduler.
module axi_dw_rd_sched_alloc
    import axi_dw_rd_sched_pkg::*;
#(
    parameter int unsigned NumSlots = 4,
    parameter int unsigned SlotW    = 2
) (
    input  logic [NumSlots-1:0]                 valid_i,
    input  logic [NumSlots-1:0][MaxIdWidth-1:0] id_i,
    input  logic [MaxIdWidth-1:0]               req_id_i,
    output logic [SlotW-1:0]                    free_idx_o,
    output logic                                full_o,
    output logic                                conflict_o
);

    always_comb begin
        free_idx_o = '0;
        full_o     = 1'b1;
        conflict_o = 1'b0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_idx_o = SlotW'(i);
                full_o     = 1'b0;
            end
        end
        for (int i = 0; i < NumSlots; i++) begin
            if (valid_i[i] && (id_i[i] == req_id_i)) begin
                conflict_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_dw_rd_sched.sv
// AR-path read scheduler for the AXI width converter; tracks per-burst lane offsets.
// Define AXI_DW_RD_SCHED_AR_SPILL_EN to insert a spill register on the master AR path.
module axi_dw_rd_sched
    import axi_dw_rd_sched_pkg::*;
#(
    parameter int unsigned AxiMaxReads         = 4,
    parameter int unsigned AxiSlvPortDataWidth = 64,
    parameter int unsigned AxiIdWidth          = 4,
    parameter type         ar_chan_t           = axi_dw_rd_sched_pkg::axi_ar_t,
    localparam int unsigned SlotW    = (AxiMaxReads > 1) ? $clog2(AxiMaxReads) : 1,
    localparam int unsigned SlvBytes = AxiSlvPortDataWidth / 8,
    localparam int unsigned OffW     = (SlvBytes > 1) ? $clog2(SlvBytes) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ar_chan_t              slv_ar_i,
    input  logic                  slv_ar_valid_i,
    output logic                  slv_ar_ready_o,
    output ar_chan_t              mst_ar_o,
    output logic                  mst_ar_valid_o,
    input  logic                  mst_ar_ready_i,
    input  logic [AxiIdWidth-1:0] r_id_i,
    input  logic                  r_last_i,
    input  logic                  r_hs_i,
    output logic                  r_hit_o,
    output logic [SlotW-1:0]      r_slot_o,
    output logic [OffW-1:0]       r_offset_o,
    output logic [2:0]            r_size_o,
    output logic                  r_err_o,
    output logic                  busy_o
);

    localparam logic [MaxOffWidth-1:0] OffMask = MaxOffWidth'(SlvBytes - 1);

    slot_t [AxiMaxReads-1:0] slot_q, slot_d;
    logic                    r_err_q, r_err_d;

    logic [AxiMaxReads-1:0]                 valid_vec;
    logic [AxiMaxReads-1:0][MaxIdWidth-1:0] id_vec;
    logic [SlotW-1:0]                       free_idx;
    logic                                   full, conflict, admit, alloc_en;
    logic                                   hit;
    logic [SlotW-1:0]                       hit_idx;
    slot_t                                  cur;

    always_comb begin
        for (int i = 0; i < AxiMaxReads; i++) begin
            valid_vec[i] = slot_q[i].valid;
            id_vec[i]    = slot_q[i].id;
        end
    end

    axi_dw_rd_sched_alloc #(
        .NumSlots (AxiMaxReads),
        .SlotW    (SlotW)
    ) i_alloc (
        .valid_i    (valid_vec),
        .id_i       (id_vec),
        .req_id_i   (MaxIdWidth'(slv_ar_i.id)),
        .free_idx_o (free_idx),
        .full_o     (full),
        .conflict_o (conflict)
    );

    assign admit = !full && !conflict && !rst_i;

`ifdef AXI_DW_RD_SCHED_AR_SPILL_EN
    logic spill_ready, rst_n;

    assign rst_n = ~rst_i;

    spill_register #(
        .T (ar_chan_t)
    ) i_ar_spill (
        .clk_i   (clk_i),
        .rst_ni  (rst_n),
        .valid_i (slv_ar_valid_i & admit),
        .ready_o (spill_ready),
        .data_i  (slv_ar_i),
        .valid_o (mst_ar_valid_o),
        .ready_i (mst_ar_ready_i),
        .data_o  (mst_ar_o)
    );

    assign slv_ar_ready_o = admit & spill_ready;
    assign alloc_en       = slv_ar_valid_i & slv_ar_ready_o;
`else
    assign mst_ar_valid_o = slv_ar_valid_i & admit;
    assign slv_ar_ready_o = mst_ar_ready_i & admit;
    assign mst_ar_o       = rst_i ? '0 : slv_ar_i;
    assign alloc_en       = slv_ar_valid_i & mst_ar_ready_i & admit;
`endif

    // IDs are unique among live slots, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < AxiMaxReads; i++) begin
            if (!hit && slot_q[i].valid &&
                (slot_q[i].id == MaxIdWidth'(r_id_i))) begin
                hit     = 1'b1;
                hit_idx = SlotW'(i);
            end
        end
        cur = slot_q[hit_idx];
    end

    assign r_hit_o    = hit & !rst_i;
    assign r_slot_o   = r_hit_o ? hit_idx : '0;
    assign r_offset_o = r_hit_o ? cur.offset[OffW-1:0] : '0;
    assign r_size_o   = r_hit_o ? cur.size : '0;
    assign r_err_o    = r_err_q;
    assign busy_o     = (|valid_vec) & !rst_i;

    always_comb begin
        slot_d  = slot_q;
        r_err_d = 1'b0;
        if (r_hs_i) begin
            if (!hit) begin
                r_err_d = 1'b1;
            end else if (r_last_i) begin
                slot_d[hit_idx].valid = 1'b0;
                r_err_d               = (cur.beats_left != 8'd0);
            end else if (cur.beats_left == 8'd0) begin
                r_err_d = 1'b1;
            end else begin
                if (cur.burst != BurstFixed) begin
                    slot_d[hit_idx].offset = next_offset(cur.offset, cur.size, OffMask);
                end
                slot_d[hit_idx].beats_left = cur.beats_left - 8'd1;
            end
        end
        // The freed slot is still valid in slot_q, so free_idx never collides with it.
        if (alloc_en) begin
            slot_d[free_idx].valid      = 1'b1;
            slot_d[free_idx].id         = MaxIdWidth'(slv_ar_i.id);
            slot_d[free_idx].offset     = MaxOffWidth'(slv_ar_i.addr[OffW-1:0]);
            slot_d[free_idx].size       = slv_ar_i.size;
            slot_d[free_idx].burst      = slv_ar_i.burst;
            slot_d[free_idx].beats_left = slv_ar_i.len;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q  <= '0;
            r_err_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            r_err_q <= r_err_d;
        end
    end

endmodule
